// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-vector multiply controller slice.
// The watchdog limit scales with the compute engine's worst-case run length.
package matmul_pkg;

    localparam int N_DEF           = 8;
    localparam int DATA_W_DEF      = 16;
    localparam int W_ADDR_BITS_DEF = 6;
    localparam int X_ADDR_BITS_DEF = 3;
    localparam int WDOG_W          = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_COMP_KICK,
        ST_COMP_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_FINISH
    } state_t;

    // N/4 lane groups, each N+3 cycles deep, four-fold margin plus fixed slack.
    function automatic int wdog_limit(input int n);
        return 4 * (n + 3) * (n / 4) + 64;
    endfunction

endpackage

// File: rtl/matmul_load_counter.sv
// Beat counter for one host-loaded buffer: counts accepted beats, flags the
// terminal beat and presents a registered write strobe/address one cycle later.
module matmul_load_counter
    import matmul_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          beat_i,
    output logic          last_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;

    assign last_o = beat_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || last_o) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            wr_en_q <= beat_i;
            if (beat_i) begin
                wr_addr_q <= cnt_q[AW-1:0];
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;

endmodule

// File: rtl/matmul_controller.sv
// Job sequencer for the 4-lane matrix-vector engine: host load of weights and
// inputs, compute kick with watchdog, then a valid/ready drain of the results.
//
// state        | meaning
// IDLE         | waiting for start
// LOAD_W       | accepting N*N weight beats
// LOAD_X       | accepting N input beats
// COMP_KICK    | one-cycle compute start pulse
// COMP_WAIT    | waiting for comp_done, watchdog running
// RD_ISSUE     | output buffer address presented
// RD_WAIT      | read data returning, captured into res_data
// RD_OUT       | result held until host accepts
// FINISH       | done pulse, back to IDLE
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int W_ADDR_BITS = W_ADDR_BITS_DEF,
    parameter int X_ADDR_BITS = X_ADDR_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic                   w_wr_en_o,
    output logic [W_ADDR_BITS-1:0] w_wr_addr_o,
    output logic                   x_wr_en_o,
    output logic [X_ADDR_BITS-1:0] x_wr_addr_o,
    output logic [DATA_W-1:0]      buf_wr_data_o,
    output logic                   comp_start_o,
    input  logic                   comp_done_i,
    output logic [X_ADDR_BITS-1:0] o_rd_addr_o,
    input  logic [DATA_W-1:0]      o_rd_data_i,
    output logic [DATA_W-1:0]      res_data_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   timeout_err_o
);

    localparam int XCW = X_ADDR_BITS + 1;
    localparam logic [XCW-1:0]    RD_LAST   = XCW'(N - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(wdog_limit(N) - 1);

    state_t              state_q;
    logic                busy_q, done_q, in_ready_q, comp_start_q;
    logic                res_valid_q, timeout_q;
    logic [DATA_W-1:0]   wr_data_q, res_data_q;
    logic [XCW-1:0]      rd_cnt_q;
    logic [WDOG_W-1:0]   wdog_q;

    logic w_beat, x_beat, w_last, x_last, job_clr;

    assign job_clr = start_i && (state_q == ST_IDLE);
    assign w_beat  = in_valid_i && in_ready_q && (state_q == ST_LOAD_W);
    assign x_beat  = in_valid_i && in_ready_q && (state_q == ST_LOAD_X);

    matmul_load_counter #(
        .DEPTH (N * N),
        .AW    (W_ADDR_BITS)
    ) u_w_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (job_clr),
        .beat_i    (w_beat),
        .last_o    (w_last),
        .wr_en_o   (w_wr_en_o),
        .wr_addr_o (w_wr_addr_o)
    );

    matmul_load_counter #(
        .DEPTH (N),
        .AW    (X_ADDR_BITS)
    ) u_x_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (job_clr),
        .beat_i    (x_beat),
        .last_o    (x_last),
        .wr_en_o   (x_wr_en_o),
        .wr_addr_o (x_wr_addr_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q <= '0;
        end else if (w_beat || x_beat) begin
            wr_data_q <= in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            comp_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            timeout_q    <= 1'b0;
            rd_cnt_q     <= '0;
            wdog_q       <= '0;
        end else begin
            done_q       <= 1'b0;
            comp_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_LOAD_W;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        timeout_q  <= 1'b0;
                        rd_cnt_q   <= '0;
                        wdog_q     <= '0;
                    end
                end
                ST_LOAD_W: begin
                    if (w_last) begin
                        state_q <= ST_LOAD_X;
                    end
                end
                ST_LOAD_X: begin
                    if (x_last) begin
                        state_q      <= ST_COMP_KICK;
                        in_ready_q   <= 1'b0;
                        comp_start_q <= 1'b1;
                    end
                end
                ST_COMP_KICK: begin
                    state_q <= ST_COMP_WAIT;
                    wdog_q  <= '0;
                end
                ST_COMP_WAIT: begin
                    // A completion arriving on the expiry cycle still counts.
                    if (comp_done_i) begin
                        state_q  <= ST_RD_ISSUE;
                        rd_cnt_q <= '0;
                    end else if (wdog_q == WDOG_LAST) begin
                        state_q   <= ST_FINISH;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                ST_RD_ISSUE: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_q     <= ST_RD_OUT;
                    res_data_q  <= o_rd_data_i;
                    res_valid_q <= 1'b1;
                end
                ST_RD_OUT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        if (rd_cnt_q == RD_LAST) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_RD_ISSUE;
                            rd_cnt_q <= rd_cnt_q + XCW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign in_ready_o    = in_ready_q;
    assign buf_wr_data_o = wr_data_q;
    assign comp_start_o  = comp_start_q;
    assign o_rd_addr_o   = rd_cnt_q[X_ADDR_BITS-1:0];
    assign res_data_o    = res_data_q;
    assign res_valid_o   = res_valid_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_matmul_controller.sv
// Directed job sequence with randomized data and host timing, checked against
// an ordered-transfer model of what the buffers and host should observe.
module tb_matmul_controller;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int WA    = 6;
    localparam int XA    = 3;
    localparam int NW    = N * N;
    localparam int LIMIT = 4 * (N + 3) * (N / 4) + 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          w_wr_en, x_wr_en;
    logic [WA-1:0] w_wr_addr;
    logic [XA-1:0] x_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic          comp_start;
    logic          comp_done = 1'b0;
    logic [XA-1:0] o_rd_addr;
    logic [DW-1:0] o_rd_data = '0;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          timeout_err;

    matmul_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .w_wr_en_o     (w_wr_en),
        .w_wr_addr_o   (w_wr_addr),
        .x_wr_en_o     (x_wr_en),
        .x_wr_addr_o   (x_wr_addr),
        .buf_wr_data_o (buf_wr_data),
        .comp_start_o  (comp_start),
        .comp_done_i   (comp_done),
        .o_rd_addr_o   (o_rd_addr),
        .o_rd_data_i   (o_rd_data),
        .res_data_o    (res_data),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] wdata [NW];
    logic [DW-1:0] xdata [N];
    logic [DW-1:0] obuf  [N];

    // Output buffer with one-cycle synchronous read.
    always @(posedge clk) o_rd_data <= obuf[o_rd_addr];

    int tests = 0;
    int fails = 0;

    int            cyc = 0;
    int            w_a[$], x_a[$], hs_cyc[$];
    logic [DW-1:0] w_d[$], x_d[$], res_q[$];
    int            cs_cnt, done_cnt, rv_cnt, cs_cyc, done_cyc;

    always @(negedge clk) begin
        cyc++;
        if (w_wr_en) begin w_a.push_back(int'(w_wr_addr)); w_d.push_back(buf_wr_data); end
        if (x_wr_en) begin x_a.push_back(int'(x_wr_addr)); x_d.push_back(buf_wr_data); end
        if (comp_start) begin cs_cnt++; cs_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (res_valid) rv_cnt++;
        if (res_valid && res_ready) begin res_q.push_back(res_data); hs_cyc.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, in_ready, w_wr_en, w_wr_addr, x_wr_en, x_wr_addr, buf_wr_data,
                comp_start, o_rd_addr, res_data, res_valid, timeout_err};
    endfunction

    task automatic clear_mon();
        w_a.delete(); w_d.delete(); x_a.delete(); x_d.delete();
        res_q.delete(); hs_cyc.delete();
        cs_cnt = 0; done_cnt = 0; rv_cnt = 0; cs_cyc = 0; done_cyc = 0;
    endtask

    task automatic fill_basic();
        for (int i = 0; i < NW; i++) wdata[i] = DW'(i);
        for (int i = 0; i < N; i++) xdata[i] = DW'(100 + i);
        for (int i = 0; i < N; i++) obuf[i] = DW'(7 * (i + 1));
    endtask

    task automatic fill_random(input bit keep_obuf);
        for (int i = 0; i < NW; i++) wdata[i] = DW'($urandom);
        for (int i = 0; i < N; i++) xdata[i] = DW'($urandom);
        if (!keep_obuf) for (int i = 0; i < N; i++) obuf[i] = DW'($urandom);
    endtask

    // gap: 0 = in_valid held high, 1 = toggled each cycle, 2 = random.
    // cdelay < 0 means the engine never completes.
    task automatic run_job(input string nm, input int gap, input bit spur_start, input int cdelay,
                           input int bp_idx, input int bp_len, input bit spur_done, input int rst_after);
        int  idx, guard, got, held, err;
        bit  tog, aborted;
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy_on_start"}, busy, 1);
        chk({nm, "_ready_on_start"}, in_ready, 1);
        chk({nm, "_start_clears_tmo"}, timeout_err, 0);

        idx = 0; guard = 0; tog = 1'b1;
        while (idx < NW + N && guard < 4000) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (idx < NW) in_data = wdata[idx];
            else          in_data = xdata[idx - NW];
            case (gap)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (spur_start && idx == NW + 2) start = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        chk({nm, "_load_beats"}, idx, NW + N);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b0;
        chk({nm, "_ready_drop"}, in_ready, 0);
        chk({nm, "_kick"}, comp_start, 1);

        aborted = 1'b0;
        if (cdelay >= 0) begin
            repeat (cdelay) @(posedge clk);
            #1 comp_done = 1'b1;
            @(posedge clk); #1 comp_done = 1'b0;

            got = 0; held = 0; guard = 0;
            while (got < N && guard < 500 && !aborted) begin
                @(posedge clk); #1;
                res_ready = !(res_valid && got == bp_idx && held < bp_len);
                comp_done = spur_done && res_valid;
                @(negedge clk);
                if (!res_ready) begin
                    held++;
                    chk({nm, "_hold_valid"}, res_valid, 1);
                    chk({nm, "_hold_data"}, res_data, obuf[bp_idx]);
                    chk({nm, "_hold_addr"}, o_rd_addr, bp_idx);
                end
                if (res_valid && res_ready) got++;
                guard++;
                if (rst_after >= 0 && got == rst_after) begin
                    @(posedge clk); #3;
                    rst_n = 1'b0;
                    #1 chk({nm, "_async_rst_outs"}, all_outs(), 0);
                    comp_done = 1'b0;
                    @(posedge clk); #1;
                    chk({nm, "_rst_held_outs"}, all_outs(), 0);
                    @(negedge clk) rst_n = 1'b1;
                    chk({nm, "_no_partial_done"}, done_cnt, 0);
                    err = 0;
                    for (int i = 0; i < res_q.size(); i++) if (res_q[i] !== obuf[i]) err++;
                    chk({nm, "_partial_results"}, (res_q.size() == rst_after) ? err : 99, 0);
                    aborted = 1'b1;
                end
            end
            comp_done = 1'b0;
            res_ready = 1'b1;
            if (!aborted) chk({nm, "_drain_count"}, got, N);
        end

        if (aborted) return;

        guard = 0;
        do begin @(negedge clk); guard++; end while (!done && guard < LIMIT + 60);
        chk({nm, "_done_seen"}, done, 1);
        chk({nm, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, done, 0);
        chk({nm, "_idle_busy"}, busy, 0);

        err = 0;
        if (w_a.size() != NW) err = 1000;
        else for (int i = 0; i < NW; i++) if (w_a[i] != i || w_d[i] !== wdata[i]) err++;
        chk({nm, "_w_writes"}, err, 0);
        err = 0;
        if (x_a.size() != N) err = 1000;
        else for (int i = 0; i < N; i++) if (x_a[i] != i || x_d[i] !== xdata[i]) err++;
        chk({nm, "_x_writes"}, err, 0);
        chk({nm, "_kick_count"}, cs_cnt, 1);
        chk({nm, "_done_count"}, done_cnt, 1);

        if (cdelay < 0) begin
            // Last honoured completion is LIMIT cycles after the kick; done follows a cycle later.
            chk({nm, "_tmo_flag"}, timeout_err, 1);
            chk({nm, "_tmo_latency"}, done_cyc - cs_cyc, LIMIT + 1);
            chk({nm, "_tmo_no_results"}, rv_cnt, 0);
        end else begin
            chk({nm, "_no_tmo"}, timeout_err, 0);
            err = 0;
            if (res_q.size() != N) err = 1000;
            else for (int i = 0; i < N; i++) if (res_q[i] !== obuf[i]) err++;
            chk({nm, "_results"}, err, 0);
            chk({nm, "_valid_cycles"}, rv_cnt, N + bp_len);
            if (bp_len == 0 && hs_cyc.size() == N)
                chk({nm, "_throughput"}, hs_cyc[N-1] - hs_cyc[0], 3 * (N - 1));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2 chk("reset_async_outs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 chk("reset_held_outs", all_outs(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) chk("post_reset_outs", all_outs(), 0);

        fill_basic();
        run_job("basic", 0, 1'b0, 20, -1, 0, 1'b0, -1);

        fill_random(1'b0);
        for (int i = 0; i < N; i++) obuf[i] = DW'(7 * (i + 1));
        run_job("gaps_bp", 1, 1'b0, int'($urandom_range(1, 60)), 3, 5, 1'b0, -1);

        fill_random(1'b0);
        run_job("spurious", 2, 1'b1, int'($urandom_range(1, 60)), -1, 0, 1'b1, -1);

        fill_random(1'b0);
        run_job("watchdog", 0, 1'b0, -1, -1, 0, 1'b0, -1);

        fill_random(1'b0);
        run_job("done_at_expiry", 2, 1'b0, LIMIT, -1, 0, 1'b0, -1);

        fill_basic();
        run_job("rst_mid_drain", 0, 1'b0, 20, -1, 0, 1'b0, 3);

        fill_random(1'b0);
        run_job("after_reset", 2, 1'b0, int'($urandom_range(1, 60)), int'($urandom_range(0, N - 1)), 2, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_controller.md
Name: matmul_controller

Overview:
- Top-level sequencer for the 4-lane matrix-vector multiply engine.
- Runs one job in four phases: load the N×N weight buffer and the N-entry input buffer from a host stream, start the compute engine (address generation + 4 MACs), then drain the N results back to the host over a valid/ready stream.
- Sits between the host/bus adapter and the buffer + compute datapath, and owns all buffer write and read ports during a job.

Parameters:
- N, 8, matrix dimension; must be a multiple of 4.
- DATA_W, 16, width of host, weight, input and result words.
- W_ADDR_BITS, 6, weight buffer address width; 2^W_ADDR_BITS >= N*N.
- X_ADDR_BITS, 3, input and output buffer address width; 2^X_ADDR_BITS >= N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; accepted only in IDLE.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at job completion.
- in_data  in  DATA_W  host load word: N*N weights row-major, then N inputs.
- in_valid  in  1  host load word valid.
- in_ready  out  1  controller accepts in_data.
- w_wr_en  out  1  weight buffer write strobe.
- w_wr_addr  out  W_ADDR_BITS  weight buffer write address.
- x_wr_en  out  1  input buffer write strobe.
- x_wr_addr  out  X_ADDR_BITS  input buffer write address.
- buf_wr_data  out  DATA_W  shared write data (registered in_data).
- comp_start  out  1  one-cycle compute engine start.
- comp_done  in  1  one-cycle compute completion pulse.
- o_rd_addr  out  X_ADDR_BITS  output buffer read address; 1-cycle synchronous read.
- o_rd_data  in  DATA_W  output buffer read data.
- res_data  out  DATA_W  result word to host.
- res_valid  out  1  result valid.
- res_ready  in  1  host accepts result.
- timeout_err  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0, including addresses, counters, buf_wr_data, res_data and timeout_err.
- States: IDLE, LOAD_W, LOAD_X, COMP_KICK, COMP_WAIT, RD_ISSUE, RD_WAIT, RD_OUT, FINISH.
- IDLE:
  - start=1 -> LOAD_W, busy=1, counters=0, timeout_err=0.
  - start in any other state is ignored.
- LOAD_W:
  - in_ready=1.
  - Each in_valid&in_ready beat registers w_wr_en=1, w_wr_addr=count, buf_wr_data=in_data on the next cycle (1-cycle write latency).
  - After beat N*N-1, go to LOAD_X with the counter cleared.
- LOAD_X:
  - Same rules using x_wr_*.
  - After beat N-1, go to COMP_KICK.
  - in_ready drops in the cycle after the last beat.
- Outside LOAD_W/LOAD_X: in_ready=0, and w_wr_en/x_wr_en are 0 except for the trailing registered write of the last beat.
- COMP_KICK: comp_start=1 for exactly one cycle -> COMP_WAIT.
- COMP_WAIT:
  - A 16-bit watchdog counts cycles.
  - comp_done -> RD_ISSUE with o_rd_addr=0.
  - Watchdog reaching 4*(N+3)*(N/4)+64 cycles -> timeout_err=1 -> FINISH (no drain).
  - comp_done in the same cycle as expiry: comp_done wins.
- RD_ISSUE: drive o_rd_addr -> RD_WAIT.
- RD_WAIT: capture o_rd_data into res_data; res_valid=1 -> RD_OUT.
- RD_OUT:
  - Hold res_data/res_valid stable until res_ready.
  - On handshake with addr<N-1: addr+1 -> RD_ISSUE.
  - On handshake with addr=N-1: -> FINISH.
  - Steady-state throughput is one result per 3 cycles. No skid buffer.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Counters are one bit wider than their address so the terminal compare never wraps. Address outputs are the truncated counter.
- comp_done outside COMP_WAIT is ignored.
- rst_n asserted mid-job: immediate return to IDLE; no partial done; buffer contents are undefined.

Decomposition:
- Package matmul_pkg:
  - state enum.
  - Watchdog limit function of N.
  - Shared defaults for N, DATA_W, W_ADDR_BITS, X_ADDR_BITS, reused by the address generator and the buffers.
- One natural sub-module: matmul_load_counter.
  - Beat counter with valid/ready handshake, terminal flag and registered write strobe/address.
  - Instantiated twice (weights and inputs) with different depth/width.

Test Plan:
- Basic job, N=8:
  - Stimulus: start, 64 weight beats 0..63 with in_valid held high, 8 input beats 100..107, comp_done 20 cycles after comp_start, output buffer preloaded 7,14,..,56, res_ready held high.
  - Response: weight writes to addr 0..63, input writes to addr 0..7, exactly one comp_start, 8 results 7..56 in order, done once, busy low afterwards.
- Host gaps: in_valid toggled 1/0 each cycle during load -> exactly 72 writes, no duplicate or skipped address, last x_wr_addr=7.
- Backpressure: res_ready low for 5 cycles on result 3 -> res_data holds 28 and res_valid stays 1 throughout; o_rd_addr stays 3 until the handshake.
- Watchdog: comp_done never asserted -> timeout_err=1 and done pulse at limit+small fixed latency, zero res_valid beats; the next start clears timeout_err.
- Spurious events:
  - start during LOAD_X and comp_done during RD_OUT -> no state change, result stream unaffected.
  - comp_done on the watchdog expiry cycle -> normal drain, timeout_err=0.
- Reset mid-drain: rst_n low after result 2 -> all outputs 0 asynchronously; after release, a fresh start produces a complete correct job.
